// File: rtl/load_store_unit.sv
// load_store_unit
//   Memory-stage load/store unit. Takes the ALU result as the effective address.
//   Issues one data-memory access at a time over a req/gnt/rvalid bus. Returns a
//   lane-aligned, sign/zero-extended load value.
//
// Optional build macro: LSU_MISALIGN_TRAP_EN
//   Defined   : a misaligned half or word access makes no bus request and
//               completes one cycle later with o_Misaligned=1.
//   Undefined : the offending low address bits are ignored and o_Misaligned
//               is tied 0.
//
// Ports
//   i_clk, i_rst                   clock and synchronous active-high reset
//   i_Valid, i_Load, i_Funct3      access request from the EX stage
//   i_Addr, i_StoreData            effective address and rs2 value
//   o_Busy, o_Done                 stall to EX, and one-cycle completion pulse
//   o_LoadData, o_Misaligned       result, valid while o_Done=1
//   o_MemReq, i_MemGnt             request handshake
//   o_MemWe, o_MemBe               write enable and byte enables
//   o_MemAddr, o_MemWdata          word-aligned address and write data
//   i_MemRvalid, i_MemRdata        response/ack, one per granted request
//
// state  | meaning
// IDLE   | waiting for i_Valid
// REQ    | o_MemReq held until i_MemGnt
// WAIT   | granted, waiting for i_MemRvalid
// DONE   | o_Done pulse, result registers valid

module load_store_unit #(
    parameter int WORD_SIZE = 32,
    parameter int BE_W      = WORD_SIZE / 8
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_Valid,
    input  logic                 i_Load,
    input  logic [2:0]           i_Funct3,
    input  logic [WORD_SIZE-1:0] i_Addr,
    input  logic [WORD_SIZE-1:0] i_StoreData,
    output logic                 o_Busy,
    output logic                 o_Done,
    output logic [WORD_SIZE-1:0] o_LoadData,
    output logic                 o_Misaligned,
    output logic                 o_MemReq,
    input  logic                 i_MemGnt,
    output logic                 o_MemWe,
    output logic [BE_W-1:0]      o_MemBe,
    output logic [WORD_SIZE-1:0] o_MemAddr,
    output logic [WORD_SIZE-1:0] o_MemWdata,
    input  logic                 i_MemRvalid,
    input  logic [WORD_SIZE-1:0] i_MemRdata
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;

    state_t                 state, next_state;
    logic                   capture, trap;

    logic [1:0]             size_d, size_q;
    logic                   unsigned_q, load_q;
    logic [BE_W-1:0]        be_d, be_q;
    logic [WORD_SIZE-1:0]   wdata_d, wdata_q, addr_q;
    logic [WORD_SIZE-1:0]   load_data_q, ext;
    logic                   misalign_d, misalign_q;
    logic [7:0]             byte_v;
    logic [15:0]            half_v;

    // Access width. Unsigned-width codes have no store form, so a store with
    // funct3[2]=1 is treated as a word, as are the reserved codes.
    always_comb begin
        size_d = SZ_W;
        if (i_Load || !i_Funct3[2]) begin
            case (i_Funct3[1:0])
                2'b00:   size_d = SZ_B;
                2'b01:   size_d = SZ_H;
                default: size_d = SZ_W;
            endcase
        end
    end

    always_comb begin
        be_d    = 4'b1111;
        wdata_d = '0;
        if (!i_Load) begin
            case (size_d)
                SZ_B: begin
                    be_d    = 4'b0001 << i_Addr[1:0];
                    wdata_d = {4{i_StoreData[7:0]}};
                end
                SZ_H: begin
                    be_d    = 4'b0011 << {i_Addr[1], 1'b0};
                    wdata_d = {2{i_StoreData[15:0]}};
                end
                default: wdata_d = i_StoreData;
            endcase
        end
    end

`ifdef LSU_MISALIGN_TRAP_EN
    assign misalign_d = ((size_d == SZ_H) && i_Addr[0]) ||
                        ((size_d == SZ_W) && (i_Addr[1:0] != 2'b00));
`else
    assign misalign_d = 1'b0;
`endif

    // Lane extraction from the returned word.
    always_comb begin
        case (addr_q[1:0])
            2'b00:   byte_v = i_MemRdata[7:0];
            2'b01:   byte_v = i_MemRdata[15:8];
            2'b10:   byte_v = i_MemRdata[23:16];
            default: byte_v = i_MemRdata[31:24];
        endcase
        half_v = addr_q[1] ? i_MemRdata[31:16] : i_MemRdata[15:0];
        case (size_q)
            SZ_B:    ext = {{24{~unsigned_q & byte_v[7]}}, byte_v};
            SZ_H:    ext = {{16{~unsigned_q & half_v[15]}}, half_v};
            default: ext = i_MemRdata;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) state <= S_IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        capture    = 1'b0;
        trap       = 1'b0;
        o_MemReq   = 1'b0;
        o_Busy     = 1'b0;
        o_Done     = 1'b0;
        case (state)
            S_IDLE: begin
                if (i_Valid) begin
                    if (misalign_d) begin
                        trap       = 1'b1;
                        next_state = S_DONE;
                    end else begin
                        next_state = S_REQ;
                    end
                end
            end
            S_REQ: begin
                o_MemReq = 1'b1;
                o_Busy   = 1'b1;
                if (i_MemGnt) begin
                    if (i_MemRvalid) begin
                        capture    = 1'b1;
                        next_state = S_DONE;
                    end else begin
                        next_state = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                o_Busy = 1'b1;
                if (i_MemRvalid) begin
                    capture    = 1'b1;
                    next_state = S_DONE;
                end
            end
            S_DONE: begin
                o_Done     = 1'b1;
                next_state = S_IDLE;
            end
            default: next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            addr_q      <= '0;
            size_q      <= SZ_B;
            unsigned_q  <= 1'b0;
            load_q      <= 1'b0;
            be_q        <= '0;
            wdata_q     <= '0;
            load_data_q <= '0;
            misalign_q  <= 1'b0;
        end else begin
            if (state == S_IDLE && i_Valid) begin
                addr_q     <= i_Addr;
                size_q     <= size_d;
                unsigned_q <= i_Funct3[2];
                load_q     <= i_Load;
                be_q       <= be_d;
                wdata_q    <= wdata_d;
            end
            if (capture) begin
                load_data_q <= load_q ? ext : '0;
                misalign_q  <= 1'b0;
            end else if (trap) begin
                load_data_q <= '0;
                misalign_q  <= 1'b1;
            end
        end
    end

    assign o_MemAddr    = {addr_q[31:2], 2'b00};
    assign o_MemBe      = be_q;
    assign o_MemWdata   = wdata_q;
    assign o_MemWe      = ~load_q & (be_q != '0);
    assign o_LoadData   = load_data_q;
    assign o_Misaligned = misalign_q;

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        i_Valid;
    logic        i_Load;
    logic [2:0]  i_Funct3;
    logic [31:0] i_Addr;
    logic [31:0] i_StoreData;
    logic        o_Busy;
    logic        o_Done;
    logic [31:0] o_LoadData;
    logic        o_Misaligned;
    logic        o_MemReq;
    logic        i_MemGnt;
    logic        o_MemWe;
    logic [3:0]  o_MemBe;
    logic [31:0] o_MemAddr;
    logic [31:0] o_MemWdata;
    logic        i_MemRvalid;
    logic [31:0] i_MemRdata;

    int errors = 0;
    int checks = 0;
    int gnt_count = 0;

    load_store_unit dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_Valid(i_Valid), .i_Load(i_Load),
        .i_Funct3(i_Funct3), .i_Addr(i_Addr), .i_StoreData(i_StoreData),
        .o_Busy(o_Busy), .o_Done(o_Done), .o_LoadData(o_LoadData),
        .o_Misaligned(o_Misaligned), .o_MemReq(o_MemReq), .i_MemGnt(i_MemGnt),
        .o_MemWe(o_MemWe), .o_MemBe(o_MemBe), .o_MemAddr(o_MemAddr),
        .o_MemWdata(o_MemWdata), .i_MemRvalid(i_MemRvalid), .i_MemRdata(i_MemRdata)
    );

    always #5 i_clk = ~i_clk;

    always @(posedge i_clk) if (o_MemReq && i_MemGnt) gnt_count++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Directed access: gnt_wait cycles of REQ without grant, then grant;
    // rv_wait=0 puts rvalid in the grant cycle, otherwise rv_wait cycles later.
    task automatic do_access(input string tag, input logic ld, input logic [2:0] f3,
                             input logic [31:0] addr, input logic [31:0] sd,
                             input int gnt_wait, input int rv_wait, input logic [31:0] rdata,
                             input logic [31:0] exp_addr, input logic [3:0] exp_be,
                             input logic [31:0] exp_wdata, input logic [31:0] exp_ld);
        int g0;
        g0 = gnt_count;
        i_Valid = 1'b1; i_Load = ld; i_Funct3 = f3; i_Addr = addr; i_StoreData = sd;
        @(negedge i_clk);
        i_Valid = 1'b0;
        for (int i = 0; i < gnt_wait; i++) begin
            check({tag, " req_hold"}, {31'd0, o_MemReq}, 32'd1);
            check({tag, " addr_hold"}, o_MemAddr, exp_addr);
            check({tag, " be_hold"}, {28'd0, o_MemBe}, {28'd0, exp_be});
            check({tag, " busy_req"}, {31'd0, o_Busy}, 32'd1);
            @(negedge i_clk);
        end
        check({tag, " req"}, {31'd0, o_MemReq}, 32'd1);
        check({tag, " we"}, {31'd0, o_MemWe}, {31'd0, ~ld});
        check({tag, " addr"}, o_MemAddr, exp_addr);
        check({tag, " be"}, {28'd0, o_MemBe}, {28'd0, exp_be});
        if (!ld) check({tag, " wdata"}, o_MemWdata, exp_wdata);
        i_MemGnt = 1'b1;
        if (rv_wait == 0) begin i_MemRvalid = 1'b1; i_MemRdata = rdata; end
        @(negedge i_clk);
        i_MemGnt = 1'b0;
        if (rv_wait > 0) begin
            for (int i = 0; i < rv_wait - 1; i++) begin
                check({tag, " req_low_wait"}, {31'd0, o_MemReq}, 32'd0);
                check({tag, " busy_wait"}, {31'd0, o_Busy}, 32'd1);
                i_Valid = (i % 2 == 0);
                i_MemRdata = 32'h5555_AAAA;
                @(negedge i_clk);
            end
            i_Valid = 1'b0;
            i_MemRvalid = 1'b1; i_MemRdata = rdata;
            @(negedge i_clk);
        end
        i_MemRvalid = 1'b0;
        check({tag, " done"}, {31'd0, o_Done}, 32'd1);
        check({tag, " busy_done"}, {31'd0, o_Busy}, 32'd0);
        check({tag, " load_data"}, o_LoadData, exp_ld);
        check({tag, " misaligned"}, {31'd0, o_Misaligned}, 32'd0);
        check({tag, " one_grant"}, gnt_count - g0, 32'd1);
        i_Valid = 1'b1;                       // ignored in DONE
        @(negedge i_clk);
        i_Valid = 1'b0;
        check({tag, " done_single"}, {31'd0, o_Done}, 32'd0);
        check({tag, " valid_in_done_ignored"}, {31'd0, o_Busy}, 32'd0);
        check({tag, " load_data_hold"}, o_LoadData, exp_ld);
    endtask

    initial begin
        i_rst = 1'b1; i_Valid = 1'b1; i_Load = 1'b1; i_Funct3 = 3'b010;
        i_Addr = 32'h0000_0100; i_StoreData = '0;
        i_MemGnt = 1'b0; i_MemRvalid = 1'b0; i_MemRdata = '0;

        repeat (3) begin
            @(negedge i_clk);
            check("rst_req", {31'd0, o_MemReq}, 32'd0);
        end
        i_rst = 1'b0; i_Valid = 1'b0;
        @(negedge i_clk);
        check("rst_busy", {31'd0, o_Busy}, 32'd0);
        check("rst_done", {31'd0, o_Done}, 32'd0);
        check("rst_be", {28'd0, o_MemBe}, 32'd0);
        check("rst_addr", o_MemAddr, 32'd0);
        check("rst_wdata", o_MemWdata, 32'd0);
        check("rst_ld", o_LoadData, 32'd0);
        check("rst_mis", {31'd0, o_Misaligned}, 32'd0);
        check("rst_we", {31'd0, o_MemWe}, 32'd0);

        do_access("LB", 1'b1, 3'b000, 32'h0000_0103, 32'h0, 0, 1, 32'h80FF_1234,
                  32'h0000_0100, 4'b1111, 32'h0, 32'hFFFF_FF80);
        do_access("LBU", 1'b1, 3'b100, 32'h0000_0103, 32'h0, 0, 0, 32'h80FF_1234,
                  32'h0000_0100, 4'b1111, 32'h0, 32'h0000_0080);
        do_access("SH", 1'b0, 3'b001, 32'h0000_0202, 32'h1234_ABCD, 3, 1, 32'hDEAD_BEEF,
                  32'h0000_0200, 4'b1100, 32'hABCD_ABCD, 32'h0);
        do_access("LW", 1'b1, 3'b010, 32'h0000_0040, 32'h0, 0, 5, 32'hCAFE_F00D,
                  32'h0000_0040, 4'b1111, 32'h0, 32'hCAFE_F00D);
        do_access("SB", 1'b0, 3'b000, 32'h0000_0001, 32'h0000_00A5, 1, 0, 32'h0,
                  32'h0000_0000, 4'b0010, 32'hA5A5_A5A5, 32'h0);
        do_access("LHU", 1'b1, 3'b101, 32'h0000_0042, 32'h0, 0, 2, 32'h9ABC_1234,
                  32'h0000_0040, 4'b1111, 32'h0, 32'h0000_9ABC);
        do_access("SW", 1'b0, 3'b010, 32'h0000_0304, 32'h0102_0304, 0, 1, 32'h0,
                  32'h0000_0304, 4'b1111, 32'h0102_0304, 32'h0);

`ifdef LSU_MISALIGN_TRAP_EN
        begin
            int g0;
            g0 = gnt_count;
            i_Valid = 1'b1; i_Load = 1'b1; i_Funct3 = 3'b001; i_Addr = 32'h0000_0041;
            @(negedge i_clk);
            i_Valid = 1'b0;
            check("LHmis done", {31'd0, o_Done}, 32'd1);
            check("LHmis flag", {31'd0, o_Misaligned}, 32'd1);
            check("LHmis ld", o_LoadData, 32'd0);
            check("LHmis req", {31'd0, o_MemReq}, 32'd0);
            @(negedge i_clk);
            check("LHmis done_single", {31'd0, o_Done}, 32'd0);
            check("LHmis no_grant", gnt_count - g0, 32'd0);
        end
`else
        do_access("LHmis", 1'b1, 3'b001, 32'h0000_0041, 32'h0, 0, 1, 32'h1234_8765,
                  32'h0000_0040, 4'b1111, 32'h0, 32'hFFFF_8765);
`endif

        // Reset while waiting for the response; a late rvalid must be dropped.
        i_Valid = 1'b1; i_Load = 1'b1; i_Funct3 = 3'b010; i_Addr = 32'h0000_0080;
        @(negedge i_clk);
        i_Valid = 1'b0; i_MemGnt = 1'b1;
        @(negedge i_clk);
        i_MemGnt = 1'b0;
        check("rstw busy_before", {31'd0, o_Busy}, 32'd1);
        i_rst = 1'b1;
        @(negedge i_clk);
        i_rst = 1'b0;
        check("rstw busy", {31'd0, o_Busy}, 32'd0);
        check("rstw req", {31'd0, o_MemReq}, 32'd0);
        i_MemRvalid = 1'b1; i_MemRdata = 32'h1111_2222;
        @(negedge i_clk);
        i_MemRvalid = 1'b0;
        check("rstw stray_done", {31'd0, o_Done}, 32'd0);
        @(negedge i_clk);
        check("rstw stray_done2", {31'd0, o_Done}, 32'd0);
        check("rstw ld", o_LoadData, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
